serial_cla_sequencer: RTL

//  Multi-cycle WIDTH-bit adder built around one 4-bit carry-lookahead nibble stage.

---
 rtl/serial_cla_pkg.sv | 14 +
 rtl/cla_nibble_stage.sv | 32 +++
 rtl/serial_cla_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/serial_cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package serial_cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/cla_nibble_stage.sv
// Purely combinational 4-bit carry-lookahead stage: s = a + b + cin.
// Carries are formed from generate/propagate terms rather than rippled.
import serial_cla_pkg::*;

module cla_nibble_stage (
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout
);

  nibble_t g_s;
  nibble_t p_s;
  nibble_t c_s;

  // Generate/propagate terms and flattened lookahead carry equations
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    c_s[0]  = cin;
    c_s[1]  = g_s[0] | (p_s[0] & cin);
    c_s[2]  = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3]  = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
            | (p_s[2] & p_s[1] & p_s[0] & cin);
    cout    = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
            | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
            | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    s       = p_s ^ c_s;
  end

endmodule

// File: rtl/serial_cla_sequencer.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle, LSB first, carry fed
// back through a register. Valid/ready request and response handshakes.
// Optional macro SERIAL_CLA_SUB_EN adds a req_sub input selecting A-B.
import serial_cla_pkg::*;

module serial_cla_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
`ifdef SERIAL_CLA_SUB_EN
  input  logic             req_sub,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  generate
    if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
      $error("serial_cla_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  seq_state_t       state_r;
  seq_state_t       state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IDX_W-1:0] nib_idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;
  logic             req_ready_r;
  logic             resp_valid_r;

  nibble_t          nib_a_s;
  nibble_t          nib_b_s;
  nibble_t          nib_sum_s;
  logic             nib_cout_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;

  // Select the operand nibbles addressed by the current nibble index
  always_comb begin
    nib_a_s = a_r[nib_idx_r*NIB_W +: NIB_W];
    nib_b_s = b_r[nib_idx_r*NIB_W +: NIB_W];
  end

  cla_nibble_stage u_stage (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .s    (nib_sum_s),
    .cout (nib_cout_s)
  );

  // Operand B and initial carry as loaded on accept (subtract inverts B, forces carry)
  always_comb begin
`ifdef SERIAL_CLA_SUB_EN
    if (req_sub) begin
      b_load_s     = ~op_b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = op_b;
      carry_load_s = carry_in;
    end
`else
    b_load_s     = op_b;
    carry_load_s = carry_in;
`endif
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (nib_idx_r == LAST_IDX) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      carry_r      <= 1'b0;
      nib_idx_r    <= {IDX_W{1'b0}};
      sum_r        <= {WIDTH{1'b0}};
      carry_out_r  <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      req_ready_r  <= (state_nxt_s == IDLE);
      resp_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            a_r       <= op_a;
            b_r       <= b_load_s;
            carry_r   <= carry_load_s;
            nib_idx_r <= {IDX_W{1'b0}};
            sum_r     <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          sum_r[nib_idx_r*NIB_W +: NIB_W] <= nib_sum_s;
          carry_r <= nib_cout_s;
          if (nib_idx_r == LAST_IDX) begin
            // Index stays on the last nibble; it is cleared on the next accept
            carry_out_r <= nib_cout_s;
          end else begin
            nib_idx_r <= nib_idx_r + IDX_ONE;
          end
        end
        DONE: begin
          // Result held until the consumer takes it
        end
        default: begin
          // Unreachable encoding; next-state logic returns to IDLE
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign sum        = sum_r;
  assign carry_out  = carry_out_r;

endmodule
